// File: rtl/updown_mod_counter_pkg.sv
// Shared types, defaults and helpers for the up/down modulo counter.
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int DEF_WIDTH = 4;

  // Out-of-range load values saturate at the top of the count range.
  function automatic int clamp_load(input int value, input int modulus);
    return (value >= modulus) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface updown_mod_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             enable;
  logic             reverse;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             wrap;

  modport master (
    output enable, reverse, load, load_val,
    input  Q, tc, wrap
  );

  modport slave (
    input  enable, reverse, load, load_val,
    output Q, tc, wrap
  );

endinterface

// File: rtl/updown_mod_counter_tff.sv
// tff_cell: single T flip-flop with asynchronous active-low clear.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_q ^ i_t;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo-MODULUS up/down counter built from one T flip-flop per bit.
// Define UDC_SATURATE_EN to hold at the terminal values instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  updown_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_Q        = WIDTH'(MODULUS - 1);
  localparam bit               NATURAL_WRAP = (MODULUS == (2**WIDTH));

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_borrow;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_q;
  dir_t             w_dir;
  logic             w_down;
  logic             w_term;
  logic             w_tc;

  assign w_dir    = dir_t'(bus.reverse);
  assign w_down   = (w_dir == DIR_DOWN);
  assign w_load_q = WIDTH'(clamp_load(int'(bus.load_val), MODULUS));
  assign w_term   = w_down ? (w_q == '0) : (w_q == MAX_Q);
  assign w_tc     = bus.enable & ~bus.load & w_term;
  assign w_step   = w_down ? w_borrow : w_carry;

  // Bit gi toggles when all lower bits are 1 (up) or all are 0 (down).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign w_carry[gi]  = 1'b1;
        assign w_borrow[gi] = 1'b1;
      end else begin : g_chain
        assign w_carry[gi]  = w_carry[gi-1] & w_q[gi-1];
        assign w_borrow[gi] = w_borrow[gi-1] & ~w_q[gi-1];
      end

      tff_cell u_tff (
        .clk   (clk),
        .rst_n (rst_n),
        .i_t   (w_toggle[gi]),
        .o_q   (w_q[gi])
      );
    end
  endgenerate

  // Toggle mask = current ^ next, so a load or a terminal jump is a single XOR.
  always_comb begin
    w_toggle = '0;
    if (bus.load) begin
      w_toggle = w_q ^ w_load_q;
`ifdef UDC_SATURATE_EN
    end else if (bus.enable && !w_term) begin
      w_toggle = w_step;
`else
    end else if (bus.enable && w_term && !NATURAL_WRAP) begin
      w_toggle = w_down ? (w_q ^ MAX_Q) : w_q;
    end else if (bus.enable) begin
      w_toggle = w_step;
`endif
    end
  end

`ifdef UDC_SATURATE_EN
  assign bus.wrap = 1'b0;
`else
  logic r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tc;
    end
  end

  assign bus.wrap = r_wrap;
`endif

  assign bus.Q  = w_q;
  assign bus.tc = w_tc;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Testbench for updown_mod_counter (WIDTH=4, MODULUS=10) against a modulo-arithmetic model.
module tb_updown_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   checks    = 0;
  int   errors    = 0;
  int   m_q       = 0;
  int   m_wrap    = 0;
  int   nstep     = 0;
  int   wrap_seen = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(W)) bus ();

  updown_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, check tc before the edge, then Q/wrap after it.
  task automatic step(input logic en, input logic rev, input logic ld, input logic [3:0] lv);
    bit at_term;
    int prev;
    bus.enable   = en;
    bus.reverse  = rev;
    bus.load     = ld;
    bus.load_val = lv;
    #1;
    at_term = rev ? (m_q == 0) : (m_q == MOD - 1);
    check("tc", 32'(bus.tc), (en && !ld && at_term) ? 1 : 0);
    @(posedge clk);
    #1;
    prev = m_q;
    if (ld) begin
      m_q = (int'(lv) >= MOD) ? MOD - 1 : int'(lv);
    end else if (en) begin
`ifdef UDC_SATURATE_EN
      if (!at_term) m_q = rev ? m_q - 1 : m_q + 1;
`else
      m_q = rev ? (m_q + MOD - 1) % MOD : (m_q + 1) % MOD;
`endif
    end
    m_wrap = (!ld && en && (rev ? (m_q > prev) : (m_q < prev))) ? 1 : 0;
    check("Q", 32'(bus.Q), m_q);
    check("wrap", 32'(bus.wrap), m_wrap);
    wrap_seen += int'(bus.wrap);
    nstep++;
    $display("step %0d en=%0b rev=%0b ld=%0b lv=%0d -> Q=%0d tc_exp=%0b wrap=%0b",
             nstep, en, rev, ld, lv, bus.Q, (en && !ld && at_term), bus.wrap);
  endtask

  // Reset pulse placed between clock edges; Q and wrap must clear without a clock.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_Q", 32'(bus.Q), 0);
    check("async_rst_wrap", 32'(bus.wrap), 0);
    m_q    = 0;
    m_wrap = 0;
    #1 rst_n = 1'b1;
    $display("async reset pulse -> Q=%0d wrap=%0b", bus.Q, bus.wrap);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.enable   = 1'b0;
    bus.reverse  = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    @(posedge clk);
    #1;
    check("reset_Q", 32'(bus.Q), 0);
    check("reset_wrap", 32'(bus.wrap), 0);
    #2 rst_n = 1'b1;

    // Up count through the wrap.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
`ifndef UDC_SATURATE_EN
    check("up12_Q", 32'(bus.Q), 2);
    check("up12_wraps", 32'(wrap_seen), 1);
`endif

    // Load 3, then count down through 0.
    wrap_seen = 0;
    step(1'b0, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
`ifndef UDC_SATURATE_EN
    check("down5_Q", 32'(bus.Q), 8);
    check("down5_wraps", 32'(wrap_seen), 1);
`endif

    // Clamped load beats enable.
    step(1'b1, 1'b0, 1'b1, 4'd14);
    check("clamp_Q", 32'(bus.Q), 9);
    check("clamp_wrap", 32'(bus.wrap), 0);

    // Direction flip at the up terminal value.
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("flip_Q", 32'(bus.Q), 8);
    check("flip_wrap", 32'(bus.wrap), 0);

    // Reset mid-cycle, held across an edge with load asserted.
    step(1'b0, 1'b0, 1'b1, 4'd5);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_Q", 32'(bus.Q), 0);
    bus.enable   = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    @(posedge clk);
    #1;
    check("rst_vs_load_Q", 32'(bus.Q), 0);
    check("rst_vs_load_wrap", 32'(bus.wrap), 0);
    #2 rst_n = 1'b1;
    m_q    = 0;
    m_wrap = 0;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("after_rst_Q", 32'(bus.Q), 1);

`ifdef UDC_SATURATE_EN
    // Saturating up count from 7.
    wrap_seen = 0;
    step(1'b0, 1'b0, 1'b1, 4'd7);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
    check("sat_Q", 32'(bus.Q), 9);
    check("sat_wraps", 32'(wrap_seen), 0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset();
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range is 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Port clk, input, 1: single rising-edge clock.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: count advances this cycle when high.
REQ-006 Port reverse, input, 1: 0 = count up, 1 = count down.
REQ-007 Port load, input, 1: synchronous parallel load strobe.
REQ-008 Port load_val, input, WIDTH: value loaded when load is high.
REQ-009 Port Q, output, WIDTH: registered count value.
REQ-010 Port tc, output, 1: combinational terminal count.
REQ-011 Port wrap, output, 1: registered one-cycle pulse after a wrap.

Function
REQ-012 Priority on each clk edge SHALL be load, then enable, then hold.
REQ-013 Load: Q <= load_val, or MODULUS-1 if load_val >= MODULUS (clamp); enable and reverse are ignored.
REQ-014 Up count (enable=1, reverse=0): Q <= Q+1; when Q == MODULUS-1, Q <= 0.
REQ-015 Down count (enable=1, reverse=1): Q <= Q-1; when Q == 0, Q <= MODULUS-1.
REQ-016 tc = enable & ~load & (reverse ? Q==0 : Q==MODULUS-1), with no register stage.
REQ-017 wrap SHALL be high for exactly the cycle after an edge on which tc was high and a wrap occurred; otherwise low.
REQ-018 Latency: Q reflects load, count or wrap one clk edge after the controlling inputs are sampled.
REQ-019 Changing reverse between cycles is legal; the new direction applies from that edge with no dead cycle.
REQ-020 Count arithmetic is modulo MODULUS only; no value >= MODULUS is ever reachable on Q.
REQ-021 MODULUS == 2**WIDTH SHALL reduce to natural binary wrap with no compare logic beyond tc.

Reset
REQ-022 rst_n low SHALL immediately force Q = 0 and wrap = 0, independent of clk.
REQ-023 A reset asserted mid-count or coincident with load SHALL win; counting resumes on the first clk edge after rst_n rises.

Configuration
REQ-024 Macro UDC_SATURATE_EN selects the terminal behaviour.
- Defined: up count holds at MODULUS-1, down count holds at 0, and wrap is tied to 0; tc is unchanged.
- Undefined: wrap-around per REQ-014 and REQ-015.

Structure
REQ-025 Package counter_pkg holds:
- typedef enum dir_t {DIR_UP, DIR_DOWN}
- localparam DEF_WIDTH = 4
- function clamp_load(value, modulus)
REQ-026 Sub-module tff_cell: a T flip-flop with asynchronous active-low clear and a toggle input.
- Instantiated once per bit.
- Per-bit toggle terms are derived from Q, reverse and the terminal compare, in ripple-carry/borrow form.

Verification (WIDTH=4, MODULUS=10)
REQ-027 Reset then enable=1, reverse=0 for 12 cycles -> Q = 1..9, 0, 1, 2; tc high when Q=9; wrap high the cycle Q=0.
REQ-028 load=1, load_val=3, then reverse=1 for 5 cycles -> Q = 3, 2, 1, 0, 9, 8; wrap pulses once after 0->9.
REQ-029 load=1 with load_val=14 while enable=1 -> Q = 9 next cycle; no count and no wrap that edge.
REQ-030 Q=5, rst_n driven low between clk edges -> Q = 0 immediately; first edge after release with enable=1 -> Q = 1.
REQ-031 Q=9 up, flip reverse on the same edge tc would fire -> Q = 8, wrap stays 0, tc deasserts.
REQ-032 UDC_SATURATE_EN defined, up count from 7 for 5 cycles -> Q = 8, 9, 9, 9, 9; wrap always 0.
